// File: rtl/id_exe_stage_ctl.sv
// ID/EXE pipeline register with per-slot valid, stall hold, branch flush and
// load-use hazard detection that inserts a single counted bubble.
module id_exe_stage_ctl #(
  parameter int DSIZE  = 16,
  parameter int ASIZE  = 3,
  parameter int ISIZE  = 16,
  parameter int OPSIZE = 3,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DSIZE-1:0]  rdata1_in,
  input  logic [DSIZE-1:0]  rdata2_in,
  input  logic [DSIZE-1:0]  imm_in,
  input  logic [OPSIZE-1:0] opcode_in,
  input  logic              alusrc_in,
  input  logic [ASIZE-1:0]  rs1_in,
  input  logic [ASIZE-1:0]  rs2_in,
  input  logic              uses_rs2_in,
  input  logic [ASIZE-1:0]  waddr_in,
  input  logic              wen_in,
  input  logic              memWrite_in,
  input  logic              memRead_in,
  input  logic              memToReg_in,
  input  logic              branch_in,
  input  logic [ISIZE-1:0]  PC_in,
  output logic              valid_out,
  output logic [DSIZE-1:0]  rdata1_out,
  output logic [DSIZE-1:0]  rdata2_out,
  output logic [DSIZE-1:0]  imm_out,
  output logic [OPSIZE-1:0] opcode_out,
  output logic              alusrc_out,
  output logic [ASIZE-1:0]  waddr_out,
  output logic              wen_out,
  output logic              memWrite_out,
  output logic              memRead_out,
  output logic              memToReg_out,
  output logic              branch_out,
  output logic [ISIZE-1:0]  PC_out,
  output logic              hazard_stall,
  output logic [CNTW-1:0]   bubble_cnt
);

  logic              valid_q,    valid_d;
  logic [DSIZE-1:0]  rdata1_q,   rdata1_d;
  logic [DSIZE-1:0]  rdata2_q,   rdata2_d;
  logic [DSIZE-1:0]  imm_q,      imm_d;
  logic [OPSIZE-1:0] opcode_q,   opcode_d;
  logic              alusrc_q,   alusrc_d;
  logic [ASIZE-1:0]  waddr_q,    waddr_d;
  logic              wen_q,      wen_d;
  logic              memwrite_q, memwrite_d;
  logic              memread_q,  memread_d;
  logic              memtoreg_q, memtoreg_d;
  logic              branch_q,   branch_d;
  logic [ISIZE-1:0]  pc_q,       pc_d;
  logic [CNTW-1:0]   bubble_cnt_q, bubble_cnt_d;

  logic hazard;
  logic load_bubble;
  logic load_new;
  logic count_bubble;

  always_comb begin
    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    hazard = valid_q & memread_q & (waddr_q != '0) &
             ((waddr_q == rs1_in) | (uses_rs2_in & (waddr_q == rs2_in))) &
             valid_in;

    load_bubble  = flush | (~stall & hazard);
    load_new     = ~flush & ~stall & ~hazard;
    count_bubble = ~flush & ~stall & hazard;

    valid_d    = valid_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    imm_d      = imm_q;
    opcode_d   = opcode_q;
    alusrc_d   = alusrc_q;
    waddr_d    = waddr_q;
    wen_d      = wen_q;
    memwrite_d = memwrite_q;
    memread_d  = memread_q;
    memtoreg_d = memtoreg_q;
    branch_d   = branch_q;
    pc_d       = pc_q;

    if (load_bubble) begin
      valid_d    = 1'b0;
      rdata1_d   = '0;
      rdata2_d   = '0;
      imm_d      = '0;
      opcode_d   = '0;
      alusrc_d   = 1'b0;
      waddr_d    = '0;
      wen_d      = 1'b0;
      memwrite_d = 1'b0;
      memread_d  = 1'b0;
      memtoreg_d = 1'b0;
      branch_d   = 1'b0;
      pc_d       = '0;
    end else if (load_new) begin
      // Control bits are qualified so an empty ID slot can never write or branch.
      valid_d    = valid_in;
      rdata1_d   = rdata1_in;
      rdata2_d   = rdata2_in;
      imm_d      = imm_in;
      opcode_d   = opcode_in;
      alusrc_d   = alusrc_in;
      waddr_d    = waddr_in;
      wen_d      = wen_in & valid_in;
      memwrite_d = memWrite_in & valid_in;
      memread_d  = memRead_in & valid_in;
      memtoreg_d = memToReg_in & valid_in;
      branch_d   = branch_in & valid_in;
      pc_d       = PC_in;
    end

    bubble_cnt_d = bubble_cnt_q;
    if (count_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      imm_q        <= '0;
      opcode_q     <= '0;
      alusrc_q     <= 1'b0;
      waddr_q      <= '0;
      wen_q        <= 1'b0;
      memwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memtoreg_q   <= 1'b0;
      branch_q     <= 1'b0;
      pc_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
      imm_q        <= imm_d;
      opcode_q     <= opcode_d;
      alusrc_q     <= alusrc_d;
      waddr_q      <= waddr_d;
      wen_q        <= wen_d;
      memwrite_q   <= memwrite_d;
      memread_q    <= memread_d;
      memtoreg_q   <= memtoreg_d;
      branch_q     <= branch_d;
      pc_q         <= pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign hazard_stall = hazard;
  assign valid_out    = valid_q;
  assign rdata1_out   = rdata1_q;
  assign rdata2_out   = rdata2_q;
  assign imm_out      = imm_q;
  assign opcode_out   = opcode_q;
  assign alusrc_out   = alusrc_q;
  assign waddr_out    = waddr_q;
  assign wen_out      = wen_q;
  assign memWrite_out = memwrite_q;
  assign memRead_out  = memread_q;
  assign memToReg_out = memtoreg_q;
  assign branch_out   = branch_q;
  assign PC_out       = pc_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_stage_ctl.sv
// Scoreboard bench for id_exe_stage_ctl: directed steps push hand-derived
// expectations, a monitor checks hazard_stall before and the registers after each edge.
module tb_id_exe_stage_ctl;

  localparam int CNTW = 2;

  typedef struct packed {
    logic        valid;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [2:0]  op;
    logic        alusrc;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        u2;
    logic [2:0]  waddr;
    logic        wen;
    logic        mw;
    logic        mr;
    logic        mtr;
    logic        br;
    logic [15:0] pc;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [2:0]  op;
    logic        alusrc;
    logic [2:0]  waddr;
    logic        wen;
    logic        mw;
    logic        mr;
    logic        mtr;
    logic        br;
    logic [15:0] pc;
    logic [CNTW-1:0] cnt;
  } out_t;

  typedef struct packed {
    logic   rst;
    logic   stall;
    logic   flush;
    instr_t in;
    logic   hz;
    out_t   exp;
  } step_t;

  typedef struct packed {
    logic hz;
    out_t exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst, stall, flush, valid_in, alusrc_in, uses_rs2_in;
  logic wen_in, memWrite_in, memRead_in, memToReg_in, branch_in;
  logic [15:0] rdata1_in, rdata2_in, imm_in, PC_in;
  logic [2:0]  opcode_in, rs1_in, rs2_in, waddr_in;
  logic valid_out, alusrc_out, wen_out, memWrite_out, memRead_out, memToReg_out, branch_out;
  logic [15:0] rdata1_out, rdata2_out, imm_out, PC_out;
  logic [2:0]  opcode_out, waddr_out;
  logic hazard_stall;
  logic [CNTW-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  step_t stim[$];
  sb_t   sbq[$];

  always #5 clk = ~clk;

  id_exe_stage_ctl #(.DSIZE(16), .ASIZE(3), .ISIZE(16), .OPSIZE(3), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in), .opcode_in(opcode_in),
    .alusrc_in(alusrc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .uses_rs2_in(uses_rs2_in),
    .waddr_in(waddr_in), .wen_in(wen_in), .memWrite_in(memWrite_in), .memRead_in(memRead_in),
    .memToReg_in(memToReg_in), .branch_in(branch_in), .PC_in(PC_in),
    .valid_out(valid_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .imm_out(imm_out),
    .opcode_out(opcode_out), .alusrc_out(alusrc_out), .waddr_out(waddr_out), .wen_out(wen_out),
    .memWrite_out(memWrite_out), .memRead_out(memRead_out), .memToReg_out(memToReg_out),
    .branch_out(branch_out), .PC_out(PC_out), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  function automatic instr_t mk(logic v, logic [15:0] r1, logic [15:0] r2, logic [15:0] im,
                                logic [2:0] op, logic as, logic [2:0] s1, logic [2:0] s2,
                                logic u2, logic [2:0] wa, logic we, logic mw, logic mr,
                                logic mt, logic br, logic [15:0] pc);
    return '{v, r1, r2, im, op, as, s1, s2, u2, wa, we, mw, mr, mt, br, pc};
  endfunction

  // Expected register image after a normal load of instruction i.
  function automatic out_t ld(instr_t i, logic [CNTW-1:0] c);
    return '{i.valid, i.rd1, i.rd2, i.imm, i.op, i.alusrc, i.waddr,
             i.wen & i.valid, i.mw & i.valid, i.mr & i.valid, i.mtr & i.valid,
             i.br & i.valid, i.pc, c};
  endfunction

  function automatic out_t bub(logic [CNTW-1:0] c);
    out_t o;
    o = '0;
    o.cnt = c;
    return o;
  endfunction

  task automatic add(logic r, logic s, logic f, instr_t i, logic hz, out_t e);
    stim.push_back('{r, s, f, i, hz, e});
  endtask

  task automatic apply(step_t st);
    rst = st.rst; stall = st.stall; flush = st.flush;
    valid_in = st.in.valid; rdata1_in = st.in.rd1; rdata2_in = st.in.rd2; imm_in = st.in.imm;
    opcode_in = st.in.op; alusrc_in = st.in.alusrc; rs1_in = st.in.rs1; rs2_in = st.in.rs2;
    uses_rs2_in = st.in.u2; waddr_in = st.in.waddr; wen_in = st.in.wen;
    memWrite_in = st.in.mw; memRead_in = st.in.mr; memToReg_in = st.in.mtr;
    branch_in = st.in.br; PC_in = st.in.pc;
  endtask

  // Monitor: hazard_stall is sampled mid-cycle, registers one step after the edge.
  initial begin : monitor
    sb_t e;
    out_t act;
    int idx;
    idx = 0;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        idx++;
        n_cmp++;
        if (hazard_stall !== e.hz) begin
          n_bad++;
          $display("FAIL hazard step %0d: got %b want %b", idx, hazard_stall, e.hz);
        end
        @(posedge clk);
        #1;
        act = '{valid_out, rdata1_out, rdata2_out, imm_out, opcode_out, alusrc_out, waddr_out,
                wen_out, memWrite_out, memRead_out, memToReg_out, branch_out, PC_out, bubble_cnt};
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL regs step %0d: got %h want %h", idx, act, e.exp);
        end
      end
    end
  end

  initial begin : driver
    instr_t nz, a, b, lw, dep, lw0, d0, d2, d3, di, s0, x1, x2, x3;
    nz  = mk(1, 16'hFFFF, 16'hAAAA, 16'h5555, 3'd7, 1, 3'd1, 3'd2, 1, 3'd7, 1, 1, 1, 1, 1, 16'hFFFF);
    a   = mk(1, 16'h1234, 16'h5678, 16'h0005, 3'b010, 1, 3'd1, 3'd4, 1, 3'd3, 1, 0, 0, 0, 0, 16'h0010);
    b   = mk(0, 16'h1111, 16'h2222, 16'h0006, 3'b011, 0, 3'd2, 3'd2, 1, 3'd5, 1, 1, 1, 1, 1, 16'h0012);
    lw  = mk(1, 16'h0100, 16'h0000, 16'h0004, 3'd0, 1, 3'd5, 3'd6, 1, 3'd2, 1, 0, 1, 1, 0, 16'h0020);
    dep = mk(1, 16'h0AAA, 16'h0BBB, 16'h0000, 3'd1, 0, 3'd2, 3'd3, 1, 3'd4, 1, 0, 0, 0, 0, 16'h0024);
    lw0 = mk(1, 16'h0200, 16'h0000, 16'h0008, 3'd0, 1, 3'd5, 3'd6, 1, 3'd0, 1, 0, 1, 1, 0, 16'h0028);
    d0  = mk(1, 16'h0CCC, 16'h0000, 16'h0000, 3'd2, 0, 3'd0, 3'd0, 1, 3'd5, 1, 0, 0, 0, 0, 16'h002C);
    d2  = mk(1, 16'h0DDD, 16'h0EEE, 16'h0000, 3'd3, 0, 3'd7, 3'd2, 0, 3'd6, 1, 0, 0, 0, 0, 16'h0030);
    d3  = mk(1, 16'h0DDD, 16'h0EEE, 16'h0000, 3'd3, 0, 3'd7, 3'd2, 1, 3'd6, 1, 0, 0, 0, 0, 16'h0034);
    di  = mk(0, 16'h0F0F, 16'h0000, 16'h0000, 3'd4, 0, 3'd2, 3'd2, 1, 3'd3, 1, 1, 0, 0, 1, 16'h0038);
    s0  = mk(1, 16'h2020, 16'h0303, 16'h0001, 3'd5, 0, 3'd3, 3'd3, 0, 3'd1, 1, 0, 0, 0, 0, 16'h0020);
    x1  = mk(1, 16'h4040, 16'h0000, 16'h0000, 3'd6, 1, 3'd2, 3'd2, 1, 3'd2, 0, 1, 1, 0, 0, 16'h0040);
    x2  = mk(0, 16'h4444, 16'h0001, 16'h0001, 3'd1, 0, 3'd1, 3'd1, 1, 3'd3, 1, 0, 0, 1, 1, 16'h0044);
    x3  = mk(1, 16'h4848, 16'h0002, 16'h0003, 3'd7, 1, 3'd4, 3'd4, 1, 3'd4, 1, 1, 0, 0, 1, 16'h0048);

    // reset with every input busy
    add(1, 0, 0, nz, 0, bub(0));
    add(1, 0, 0, nz, 0, bub(0));
    // normal flow, then an invalid slot whose controls must be gated off
    add(0, 0, 0, a, 0, ld(a, 0));
    add(0, 0, 0, b, 0, ld(b, 0));
    // load-use on rs1: one bubble, then the dependent instruction loads
    add(0, 0, 0, lw, 0, ld(lw, 0));
    add(0, 0, 0, dep, 1, bub(1));
    add(0, 0, 0, dep, 0, ld(dep, 1));
    // load to r0 never hazards
    add(0, 0, 0, lw0, 0, ld(lw0, 1));
    add(0, 0, 0, d0, 0, ld(d0, 1));
    // rs2 match ignored unless the instruction reads rs2
    add(0, 0, 0, lw, 0, ld(lw, 1));
    add(0, 0, 0, d2, 0, ld(d2, 1));
    add(0, 0, 0, lw, 0, ld(lw, 1));
    add(0, 0, 0, d3, 1, bub(2));
    add(0, 0, 0, d3, 0, ld(d3, 2));
    // invalid ID slot never hazards
    add(0, 0, 0, lw, 0, ld(lw, 2));
    add(0, 0, 0, di, 0, ld(di, 2));
    // stall hold for three cycles with changing inputs
    add(0, 0, 0, s0, 0, ld(s0, 2));
    add(0, 1, 0, x1, 0, ld(s0, 2));
    add(0, 1, 0, x2, 0, ld(s0, 2));
    add(0, 1, 0, x3, 0, ld(s0, 2));
    add(0, 0, 0, x3, 0, ld(x3, 2));
    // hazard + flush + stall: bubble, not counted
    add(0, 0, 0, lw, 0, ld(lw, 2));
    add(0, 1, 1, dep, 1, bub(2));
    // hazard + stall: hold with hazard_stall still high
    add(0, 0, 0, lw, 0, ld(lw, 2));
    add(0, 1, 0, dep, 1, ld(lw, 2));
    add(0, 1, 0, dep, 1, ld(lw, 2));
    add(0, 0, 0, dep, 1, bub(3));
    add(0, 0, 0, dep, 0, ld(dep, 3));
    // saturation of the 2-bit counter: 1,2,3,3,3
    add(1, 0, 0, nz, 0, bub(0));
    for (int k = 0; k < 5; k++) begin
      add(0, 0, 0, lw, 0, ld(lw, (k < 3) ? CNTW'(k) : CNTW'(3)));
      add(0, 0, 0, dep, 1, bub((k < 2) ? CNTW'(k + 1) : CNTW'(3)));
    end
    // reset overrides a pending hazard, and a hazard under stall
    add(0, 0, 0, lw, 0, ld(lw, 3));
    add(1, 0, 0, dep, 1, bub(0));
    add(0, 0, 0, lw, 0, ld(lw, 0));
    add(1, 1, 0, dep, 1, bub(0));
    add(0, 0, 0, a, 0, ld(a, 0));

    apply('{1'b1, 1'b0, 1'b0, instr_t'('0), 1'b0, out_t'('0)});
    foreach (stim[i]) begin
      @(negedge clk);
      apply(stim[i]);
      sbq.push_back('{stim[i].hz, stim[i].exp});
    end
    for (int w = 0; w < 4 && sbq.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_exe_stage_ctl.md
Name: id_exe_stage_ctl

Overview:
- Parametrised ID/EXE pipeline register for the 5-stage core. Generalises the plain ID/EXE latch with per-stage valid, downstream stall hold, branch flush, and built-in load-use hazard detection with bubble insertion.
- Sits between the decode stage and the ALU/EXE stage.
- Drives `hazard_stall` back to PC/IF-ID so they hold while a bubble is inserted.

Parameters:
- DSIZE, 16, datapath width (rdata1, rdata2, imm)
- ASIZE, 3, register-file address width (waddr, rs1, rs2)
- ISIZE, 16, PC width
- OPSIZE, 3, ALU opcode width
- CNTW, 8, width of saturating bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  downstream hold (EXE/MEM busy); register keeps contents
- flush  in  1  branch-taken squash; loads bubble
- valid_in  in  1  ID stage holds a real instruction
- rdata1_in  in  DSIZE  operand 1
- rdata2_in  in  DSIZE  operand 2
- imm_in  in  DSIZE  sign-extended immediate
- opcode_in  in  OPSIZE  ALU op
- alusrc_in  in  1  ALU B select (1 = imm)
- rs1_in  in  ASIZE  source reg 1 of instruction in ID
- rs2_in  in  ASIZE  source reg 2 of instruction in ID
- uses_rs2_in  in  1  instruction in ID reads rs2
- waddr_in  in  ASIZE  destination reg
- wen_in, memWrite_in, memRead_in, memToReg_in, branch_in  in  1 each  control bits
- PC_in  in  ISIZE  PC of instruction in ID
- valid_out  out  1  EXE holds a real instruction
- rdata1_out, rdata2_out, imm_out  out  DSIZE  registered copies
- opcode_out  out  OPSIZE  registered copy
- alusrc_out  out  1  registered copy
- waddr_out  out  ASIZE  registered copy
- wen_out, memWrite_out, memRead_out, memToReg_out, branch_out  out  1 each  registered copies; gated by valid
- PC_out  out  ISIZE  registered copy
- hazard_stall  out  1  combinational; load-use hazard detected, upstream must hold
- bubble_cnt  out  CNTW  count of hazard bubbles inserted

Behaviour:
- Reset (rst=1 at posedge): every registered output, valid_out and bubble_cnt go to 0. hazard_stall is therefore 0 the cycle after reset. Reset overrides every other input, including mid-stall and mid-hazard.
- Hazard (combinational): `hazard_stall = valid_out & memRead_out & (waddr_out != 0) & ((waddr_out == rs1_in) | (uses_rs2_in & (waddr_out == rs2_in))) & valid_in`.
  - Register 0 never causes a hazard.
- Update priority at each posedge (rst=0):
  1. **flush**: load bubble.
  2. **stall**: hold all outputs and bubble_cnt unchanged.
  3. **hazard_stall**: load bubble; bubble_cnt += 1.
  4. Otherwise: load all *_in fields, valid_out <= valid_in.
- Bubble definition:
  - valid_out=0; wen, memWrite, memRead, memToReg, branch = 0.
  - opcode=0, alusrc=0, waddr=0; data fields and PC = 0.
- Control gating on normal load: control bits are loaded as `*_in & valid_in`. An invalid ID slot never writes or branches.
- Latency: 1 cycle ID→EXE on normal load. A load-use pair incurs exactly one bubble; the hazard self-clears once the load advances.
- Flush concurrent with hazard:
  - Flush wins; a bubble is loaded.
  - bubble_cnt is not incremented (flushes are not counted).
- Stall concurrent with hazard: registers hold; hazard_stall remains asserted (driven from current regs); bubble_cnt unchanged.
- Stall concurrent with flush: flush wins.
- bubble_cnt saturates at 2^CNTW-1; no wrap.
- No other state; no combinational path from *_in data to outputs except via hazard_stall.

Test Plan:
- **Reset**: drive all inputs nonzero, rst=1 for 2 cycles → all outputs 0, bubble_cnt=0, hazard_stall=0.
- **Normal flow**: valid_in=1, rdata1=0x1234, imm=0x0005, opcode=3'b010, waddr=3, wen=1, PC=0x0010 → next cycle outputs match exactly, valid_out=1. Repeat with valid_in=0, wen_in=1 → wen_out=0, valid_out=0.
- **Load-use**:
  - Cycle n: load `lw r2` (memRead=1, waddr=2).
  - Cycle n+1: ID has rs1=2 → hazard_stall=1; at posedge a bubble is loaded (valid_out=0, memRead_out=0) and bubble_cnt=1.
  - Next cycle hazard_stall=0 and the dependent instruction loads.
  - Same test with waddr=0 → no hazard; with rs2=2, uses_rs2_in=0 → no hazard.
- **Stall hold**: load instr (PC=0x0020), assert stall 3 cycles with changing inputs → outputs constant at PC_out=0x0020. Deassert → the new input loads next edge.
- **Flush priority**:
  - Hazard condition active + flush=1 + stall=1 same cycle → bubble loaded, bubble_cnt unchanged, valid_out=0.
  - Hazard + stall (no flush) → hold, hazard_stall=1.
- **Saturation**: CNTW=2, force 5 consecutive load-use hazards → bubble_cnt reads 1,2,3,3,3. Assert rst mid-sequence → 0 next cycle.
